sha_work_reg_bank: RTL

Parametrised successor to the single enable-register: a bank of eight WIDTH-bit hash registers (H0..H7) and eight working registers (A..H) for the compression core.
- Loads the initial value (IV) into the hash registers.
- Copies hash to working registers at block start, then shifts A..H once per round for ROUNDS rounds using the round results from the compression datapath.
- Finally accumulates H_i += work_i modulo 2^WIDTH and pulses done_o.
- Sits between the message scheduler/round logic and the digest output.

---
 rtl/sha_pkg.sv | 22 ++
 rtl/sha_word_adder.sv | 13 +
 rtl/sha_work_reg_bank.sv | 117 +++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA working/hash register bank.
// Holds the controller state type, the standard word/round sizes and the SHA-256 IV.
package sha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ACCUM = 2'd2
  } sha_state_e;

  localparam int SHA256_WIDTH  = 32;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_WIDTH  = 64;
  localparam int SHA512_ROUNDS = 80;

  // Word 0 (H0) sits in the least significant bits, matching the iv_i layout.
  localparam logic [8*32-1:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

endpackage

// File: rtl/sha_word_adder.sv
// Modulo-2^WIDTH word adder used for the final hash accumulation.
// The carry out of the top bit is discarded by construction.
module sha_word_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/sha_work_reg_bank.sv
// Hash (H0..H7) and working (A..H) register bank for a SHA compression core:
// IV load, per-round A..H shift from external round results, and final accumulation.
module sha_work_reg_bank
  import sha_pkg::*;
#(
  parameter int  WIDTH  = SHA256_WIDTH,
  parameter int  ROUNDS = SHA256_ROUNDS,
  localparam int CNT_W  = $clog2(ROUNDS)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               init,
  input  logic [8*WIDTH-1:0] iv_i,
  input  logic               start,
  input  logic [WIDTH-1:0]   new_a_i,
  input  logic [WIDTH-1:0]   new_e_i,
  output logic               busy_o,
  output logic [CNT_W-1:0]   round_o,
  output logic               done_o,
  output logic [8*WIDTH-1:0] work_o,
  output logic [8*WIDTH-1:0] hash_o
);

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

  sha_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hash_q [8];
  logic [WIDTH-1:0] hash_d [8];
  logic [WIDTH-1:0] work_q [8];
  logic [WIDTH-1:0] work_d [8];
  logic [WIDTH-1:0] iv_word [8];
  logic [WIDTH-1:0] sum_word [8];

  for (genvar i = 0; i < 8; i++) begin : g_word
    assign iv_word[i] = iv_i[i*WIDTH +: WIDTH];

    sha_word_adder #(.WIDTH(WIDTH)) u_adder (
      .a_i   (hash_q[i]),
      .b_i   (work_q[i]),
      .sum_o (sum_word[i])
    );

    assign work_o[i*WIDTH +: WIDTH] = work_q[i];
    assign hash_o[i*WIDTH +: WIDTH] = hash_q[i];
  end

  always_comb begin
    // NOTE: every _d gets a hold value first so no path through the case leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hash_d  = hash_q;
    work_d  = work_q;

    case (state_q)
      ST_IDLE: begin
        if (init) begin
          hash_d = iv_word;
        end else if (start) begin
          work_d  = hash_q;
          cnt_d   = '0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        // A..D and E..H are two independent shift chains fed by the round results.
        work_d[0] = new_a_i;
        work_d[1] = work_q[0];
        work_d[2] = work_q[1];
        work_d[3] = work_q[2];
        work_d[4] = new_e_i;
        work_d[5] = work_q[4];
        work_d[6] = work_q[5];
        work_d[7] = work_q[6];
        if (cnt_q == LAST_ROUND) begin
          state_d = ST_ACCUM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACCUM: begin
        hash_d  = sum_word;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      // NOTE: these register arrays are real state observable on the outputs, so they are cleared
      // explicitly; a RAM-style array would normally be left unreset.
      for (int i = 0; i < 8; i++) begin
        hash_q[i] <= '0;
        work_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hash_q  <= hash_d;
      work_q  <= work_d;
    end
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign round_o = cnt_q;
  assign done_o  = done_q;

endmodule
